// File: rtl/pwm_rx_pkg.sv
// -----------------------------------------------------------------------------
// pwm_rx_pkg
//   Shared constants and types for the PWM sample decoder. The default frame
//   constants match the synth's PWM generator so both ends agree on the frame
//   length.
//   Contents:
//     PWM_WIDTH / PWM_PERIOD / PWM_TOL  default sample width, frame length, tolerance
//     rx_state_e                        decoder state (HUNT, MEASURE, LOCKED)
//     pwm_cnt_width()                   counter width needed to reach PERIOD+TOL
// -----------------------------------------------------------------------------
package pwm_rx_pkg;

    localparam int PWM_WIDTH  = 8;
    localparam int PWM_PERIOD = 255;
    localparam int PWM_TOL    = 2;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_e;

    function automatic int pwm_cnt_width(input int period, input int tol);
        return $clog2(period + tol + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous pin into the clk domain through two flops. A third
//   flop holds the previous synchronized level, which gives a rising-edge strobe.
//   Ports:
//     clk      in   system clock
//     n_rst    in   synchronous active-low reset; clears all three flops
//     i_d      in   asynchronous input level
//     o_s      out  synchronized level
//     o_rise   out  one-cycle strobe: o_s is high and was low last cycle
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic i_d,
    output logic o_s,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_s    = r_sync;
    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pwm_sample_decoder.sv
// -----------------------------------------------------------------------------
// pwm_sample_decoder
//   Recovers duty-cycle samples from a PWM waveform on a GPIO pin. A frame runs
//   from one rising edge to the next. When the frame length is within TOL of
//   PERIOD, the high-cycle count becomes the sample. A pin that stays at one
//   level is reported as a 0% or 100% sample once per timeout window.
//   Ports:
//     clk       in   system clock
//     n_rst     in   synchronous active-low reset
//     en        in   decoder enable; low forces HUNT
//     pwm_i     in   asynchronous PWM input
//     sample_o  out  last recovered sample (clamped to 2**WIDTH-1)
//     valid_o   out  one-cycle pulse when sample_o updates
//     locked_o  out  high while consecutive in-tolerance frames are seen
//     err_o     out  one-cycle pulse for an out-of-tolerance frame
// -----------------------------------------------------------------------------
module pwm_sample_decoder
    import pwm_rx_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int PERIOD = PWM_PERIOD,
    parameter int TOL    = PWM_TOL
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    localparam int              CW       = pwm_cnt_width(PERIOD, TOL);
    localparam int              SMAX     = (2 ** WIDTH) - 1;
    localparam logic [CW-1:0]   PCNT_MAX = CW'(PERIOD + TOL);
    localparam logic [CW-1:0]   PCNT_LO  = CW'(PERIOD - TOL);

    logic            w_s;
    logic            w_rise;
    logic            w_in_tol;
    logic            w_timeout;
    logic [WIDTH-1:0] w_clamped;

    rx_state_e       r_state;
    logic [CW-1:0]   r_pcnt;
    logic [CW-1:0]   r_hcnt;
    logic [WIDTH-1:0] r_sample;
    logic            r_valid;
    logic            r_locked;
    logic            r_err;

    sync_edge_detect u_sync (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_d    (pwm_i),
        .o_s    (w_s),
        .o_rise (w_rise)
    );

    // The counters reset to 1 on a rise, so r_pcnt at the next rise equals the
    // edge-to-edge distance in cycles.
    assign w_in_tol  = (r_pcnt >= PCNT_LO) && (r_pcnt <= PCNT_MAX);
    // A rise in the same cycle still takes priority (see the FSM ordering).
    assign w_timeout = (r_pcnt == PCNT_MAX);

    always_comb begin
        w_clamped = WIDTH'(r_hcnt);
        if (int'(r_hcnt) > SMAX)
            w_clamped = '1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= HUNT;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else if (!en) begin
            // Idle: drop the lock and any partial frame. The last sample is kept.
            r_state  <= HUNT;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                HUNT: begin
                    // The partial frame before the first edge cannot be trusted.
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_pcnt  <= CW'(1);
                        r_hcnt  <= CW'(1);
                    end else begin
                        r_pcnt <= '0;
                        r_hcnt <= '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (w_rise) begin
                        if (w_in_tol) begin
                            r_sample <= w_clamped;
                            r_valid  <= 1'b1;
                            r_locked <= 1'b1;
                            r_state  <= LOCKED;
                        end else begin
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            r_state  <= MEASURE;
                        end
                        // The rise cycle itself is the first high cycle of the new frame.
                        r_pcnt <= CW'(1);
                        r_hcnt <= CW'(1);
                    end else if (w_timeout) begin
                        // No edge for a whole window: the pin is stuck at 0% or 100%.
                        r_sample <= w_s ? WIDTH'(SMAX) : '0;
                        r_valid  <= 1'b1;
                        r_locked <= 1'b0;
                        r_state  <= MEASURE;
                        r_pcnt   <= '0;
                        r_hcnt   <= '0;
                    end else begin
                        if (r_pcnt != PCNT_MAX)
                            r_pcnt <= r_pcnt + CW'(1);
                        r_hcnt <= r_hcnt + CW'(w_s);
                    end
                end
                default: begin
                    r_state <= HUNT;
                    r_pcnt  <= '0;
                    r_hcnt  <= '0;
                end
            endcase
        end
    end

    assign sample_o = r_sample;
    assign valid_o  = r_valid;
    assign locked_o = r_locked;
    assign err_o    = r_err;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
module tb_pwm_sample_decoder;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 255;
    localparam int TOL    = 2;
    localparam int SMAX   = 255;
    localparam int MAXC   = 60000;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             en = 1'b0;
    logic             pwm_i = 1'b0;
    logic [WIDTH-1:0] sample_o;
    logic             valid_o;
    logic             locked_o;
    logic             err_o;

    pwm_sample_decoder #(.WIDTH(WIDTH), .PERIOD(PERIOD), .TOL(TOL)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .pwm_i    (pwm_i),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int smp;
        int ev_edge;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // ---------------- reference model (timestamp based) ----------------
    // ph[e] is the pin level sampled at clock edge e. The decoder acts on a level
    // that is two edges old, and that level reads as 0 if a reset is that recent.
    bit ph[MAXC];
    int cyc = 0;
    int last_rst = -10;
    bit hunting = 1'b1;
    int start = 0;
    int exp_sample = 0;
    bit exp_locked = 1'b0;

    function automatic bit s_at(input int k);
        if (k - 2 < 0 || k - 2 <= last_rst) return 1'b0;
        return ph[k-2];
    endfunction

    function automatic int highs(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) n += int'(s_at(k));
        return n;
    endfunction

    always @(posedge clk) begin
        int e, len, h;
        bit s_e, rise;
        exp_t it;
        e = cyc;
        if (e < MAXC) ph[e] = pwm_i;
        if (!n_rst) begin
            last_rst   = e;
            hunting    = 1'b1;
            exp_locked = 1'b0;
            exp_sample = 0;
        end else begin
            s_e  = s_at(e);
            rise = s_e && !s_at(e - 1);
            if (!en) begin
                hunting    = 1'b1;
                exp_locked = 1'b0;
            end else if (hunting) begin
                if (rise) begin
                    hunting = 1'b0;
                    start   = e;
                end
            end else begin
                len = e - start;
                if (rise) begin
                    if (len >= PERIOD - TOL && len <= PERIOD + TOL) begin
                        h          = highs(start, e - 1);
                        exp_sample = (h > SMAX) ? SMAX : h;
                        exp_locked = 1'b1;
                        it = '{is_err: 1'b0, smp: exp_sample, ev_edge: e};
                    end else begin
                        exp_locked = 1'b0;
                        it = '{is_err: 1'b1, smp: exp_sample, ev_edge: e};
                    end
                    q.push_back(it);
                    start = e;
                end else if (len == PERIOD + TOL) begin
                    exp_sample = s_e ? SMAX : 0;
                    exp_locked = 1'b0;
                    it = '{is_err: 1'b0, smp: exp_sample, ev_edge: e};
                    q.push_back(it);
                    start = e + 1;
                end
            end
        end
        cyc = e + 1;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t it;
        if (cyc > 0) begin
            n_cmp++;
            if (int'(sample_o) != exp_sample) begin
                n_bad++;
                $display("FAIL sample edge=%0d got=%0d exp=%0d", cyc - 1, sample_o, exp_sample);
            end
            n_cmp++;
            if (locked_o !== exp_locked) begin
                n_bad++;
                $display("FAIL locked edge=%0d got=%0b exp=%0b", cyc - 1, locked_o, exp_locked);
            end
            if (valid_o === 1'b1 && err_o === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_err_both edge=%0d got=1/1 exp=not both", cyc - 1);
            end
            while (q.size() > 0 && q[0].ev_edge < cyc - 1) begin
                it = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event edge=%0d got=none exp=%s smp=%0d", it.ev_edge,
                         it.is_err ? "err" : "valid", it.smp);
            end
            if (valid_o === 1'b1 || err_o === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event edge=%0d got=v%0b/e%0b exp=none", cyc - 1, valid_o, err_o);
                end else begin
                    it = q.pop_front();
                    if (it.is_err != err_o || it.ev_edge != cyc - 1 || it.smp != int'(sample_o)) begin
                        n_bad++;
                        $display("FAIL event edge=%0d got=err%0b smp=%0d exp=err%0b smp=%0d at edge %0d",
                                 cyc - 1, err_o, sample_o, it.is_err, it.smp, it.ev_edge);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit lvl, input int n);
        repeat (n) begin
            pwm_i = lvl;
            @(negedge clk);
        end
    endtask

    task automatic frame(input int len, input int hi);
        drive(1'b1, hi);
        drive(1'b0, len - hi);
    endtask

    initial begin
        int len, hi;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        drive(1'b0, 4);
        en = 1'b1;
        drive(1'b0, 10);
        // lock-up on 100/255
        repeat (3) frame(255, 100);
        // one short frame, then relock on duty 40
        frame(250, 100);
        repeat (3) frame(255, 40);
        // constant low, then constant high, then relock
        drive(1'b0, 600);
        drive(1'b1, 600);
        drive(1'b0, 30);
        repeat (3) frame(255, 77);
        // tolerance edges, clamping, just-outside frames
        frame(257, 256);
        frame(253, 200);
        frame(255, 10);
        frame(258, 5);
        frame(252, 5);
        repeat (2) frame(255, 128);
        // reset for a single edge mid-frame
        drive(1'b1, 50);
        drive(1'b0, 60);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        drive(1'b0, 145);
        repeat (3) frame(255, 60);
        // enable dropped mid-frame
        repeat (2) frame(255, 90);
        drive(1'b1, 30);
        en = 1'b0;
        drive(1'b1, 30);
        drive(1'b0, 40);
        en = 1'b1;
        drive(1'b0, 100);
        repeat (3) frame(255, 90);
        // randomized frames around the nominal length
        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(PERIOD + TOL + 3, PERIOD - TOL - 3);
            hi  = $urandom_range(len - 1, 1);
            frame(len, hi);
        end
        drive(1'b0, 600);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events got=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
